vga_timing: RTL and testbench
=============================

VGA_TIMING -- requirements
Module: vga_timing

Interface
REQ-001 The module SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 The module SHALL have parameter H_FP, default 16, horizontal front porch in pixels.
REQ-003 The module SHALL have parameter H_SYNC, default 96, horizontal sync width in pixels.
REQ-004 The module SHALL have parameter H_BP, default 48, horizontal back porch in pixels.
REQ-005 The module SHALL have parameter V_ACTIVE, default 480, visible lines per frame.
REQ-006 The module SHALL have parameters V_FP/V_SYNC/V_BP, defaults 10/2/33, vertical porches and sync in lines.
REQ-007 Port: CLOCK_50  input  1  50 MHz system clock; the only clock.
REQ-008 Port: reset  input  1  asynchronous, active-low reset.
REQ-009 Port: rgb_in  input  24  {R,G,B} from the renderer for the current pixel_x/pixel_y.
REQ-010 Port: pixel_x  output  10  horizontal counter, 0..H_total-1.
REQ-011 Port: pixel_y  output  10  vertical counter, 0..V_total-1.
REQ-012 Port: frame_tick  output  1  one-CLOCK_50 pulse at start of vertical blanking.
REQ-013 Port: frame_count  output  8  frames completed, wraps.
REQ-014 Port: VGA_CLK  output  1  25 MHz pixel clock, CLOCK_50 divided by 2.
REQ-015 Port: VGA_HS, VGA_VS  output  1 each  syncs, active low.
REQ-016 Port: VGA_BLANK_N  output  1  high during visible area.
REQ-017 Port: VGA_R, VGA_G, VGA_B  output  8 each  registered colour.

Function
REQ-018 An internal pixel enable SHALL be asserted on every second CLOCK_50 cycle; all counters and VGA outputs SHALL update only on enabled cycles.
REQ-019 VGA_CLK SHALL be a register toggling every CLOCK_50 cycle, rising in the cycle the pixel enable is asserted.
REQ-020 H_total = H_ACTIVE+H_FP+H_SYNC+H_BP (800); pixel_x SHALL increment per pixel and wrap H_total-1 -> 0.
REQ-021 pixel_y SHALL increment when pixel_x wraps; V_total = V_ACTIVE+V_FP+V_SYNC+V_BP (525); wrap V_total-1 -> 0 at pixel_x wrap.
REQ-022 Visible area: pixel_x < H_ACTIVE and pixel_y < V_ACTIVE.
REQ-023 Raw HS low for H_ACTIVE+H_FP <= pixel_x < H_ACTIVE+H_FP+H_SYNC (656..751).
REQ-024 Raw VS low for V_ACTIVE+V_FP <= pixel_y < V_ACTIVE+V_FP+V_SYNC (490..491).
REQ-025 VGA_R/G/B SHALL register rgb_in when visible, else 0x00, one pixel after the coordinate is presented.
REQ-026 VGA_HS, VGA_VS, VGA_BLANK_N SHALL be delayed by the same one pixel so they align with VGA_R/G/B.
REQ-027 frame_tick SHALL assert for exactly one CLOCK_50 cycle, the enabled cycle in which the counters become pixel_x=0, pixel_y=V_ACTIVE.
REQ-028 frame_count SHALL increment by 1 (mod 256) in the same cycle frame_tick asserts.
REQ-029 pixel_x/pixel_y SHALL be registered outputs, never combinational.
REQ-030 Out-of-range parameter sums exceeding 1023 are unsupported; no checking required.

Reset
REQ-031 While reset=0: pixel_x=0, pixel_y=0, pixel enable phase=0, VGA_CLK=0, frame_tick=0, frame_count=0, VGA_HS=1, VGA_VS=1, VGA_BLANK_N=0, VGA_R/G/B=0.
REQ-032 Reset asserted mid-frame SHALL clear all state immediately; after release the first enabled cycle SHALL advance pixel_x to 1 from 0,0.
REQ-033 No output SHALL glitch on reset release; first change occurs on the first enabled edge.

Verification
REQ-034 Release reset, run 2*800*525 CLOCK_50 cycles -> pixel_x=0, pixel_y=0 again, frame_count=1, exactly one frame_tick seen.
REQ-035 Count per line -> VGA_HS low exactly 96 pixels, starting one pixel after pixel_x=656; VGA_BLANK_N high 640 pixels.
REQ-036 Count per frame -> VGA_VS low exactly 2 lines (1600 pixels), starting after pixel_y=490 delayed one pixel.
REQ-037 rgb_in=0xFF8040 constant -> VGA_R/G/B=FF/80/40 in visible area, 00/00/00 during blanking, first visible pixel one pixel after (0,0).
REQ-038 Assert reset at pixel_x=300, pixel_y=200 -> all outputs return to reset values in same cycle; frame_count=0.
REQ-039 Run 256 frames -> frame_count wraps 255 -> 0 on the 256th frame_tick.

Source files
------------

// File: rtl/vga_timing.sv
// VGA raster timing generator: CLOCK_50 divided to a pixel enable, free-running
// x/y counters, and sync/blank/colour outputs registered one pixel behind the counters.
module vga_timing #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic [23:0] rgb_in,
  output logic [9:0]  pixel_x,
  output logic [9:0]  pixel_y,
  output logic        frame_tick,
  output logic [7:0]  frame_count,
  output logic        VGA_CLK,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        VGA_BLANK_N,
  output logic [7:0]  VGA_R,
  output logic [7:0]  VGA_G,
  output logic [7:0]  VGA_B
);

  localparam logic [9:0] H_VIS   = 10'(H_ACTIVE);
  localparam logic [9:0] H_SS    = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_SE    = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] H_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_VIS   = 10'(V_ACTIVE);
  localparam logic [9:0] V_SS    = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_SE    = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] V_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] V_TICKY = 10'(V_ACTIVE - 1);

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        blank_n;
    logic [23:0] rgb;
  } vid_t;

  localparam vid_t VID_RST = '{hs: 1'b1, vs: 1'b1, blank_n: 1'b0, rgb: 24'h0};

  logic       phase_q, phase_d;
  logic [9:0] x_q, x_d;
  logic [9:0] y_q, y_d;
  logic       tick_q, tick_d;
  logic [7:0] fcnt_q, fcnt_d;
  vid_t       vid_q, vid_d;

  logic pix_en;
  logic x_last, y_last, visible;

  // phase_q doubles as VGA_CLK: the enabled edge is the one where it rises
  assign pix_en  = ~phase_q;
  assign x_last  = (x_q == H_LAST);
  assign y_last  = (y_q == V_LAST);
  assign visible = (x_q < H_VIS) && (y_q < V_VIS);

  always_comb begin
    phase_d = ~phase_q;
    x_d     = x_q;
    y_d     = y_q;
    tick_d  = 1'b0;
    fcnt_d  = fcnt_q;
    vid_d   = vid_q;
    if (pix_en) begin
      x_d = x_last ? 10'd0 : x_q + 10'd1;
      if (x_last) y_d = y_last ? 10'd0 : y_q + 10'd1;
      // counters about to land on (0, V_ACTIVE): start of vertical blanking
      if (x_last && (y_q == V_TICKY)) begin
        tick_d = 1'b1;
        fcnt_d = fcnt_q + 8'd1;
      end
      vid_d.hs      = ~((x_q >= H_SS) && (x_q < H_SE));
      vid_d.vs      = ~((y_q >= V_SS) && (y_q < V_SE));
      vid_d.blank_n = visible;
      vid_d.rgb     = visible ? rgb_in : 24'h0;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      phase_q <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      tick_q  <= 1'b0;
      fcnt_q  <= '0;
      vid_q   <= VID_RST;
    end else begin
      phase_q <= phase_d;
      x_q     <= x_d;
      y_q     <= y_d;
      tick_q  <= tick_d;
      fcnt_q  <= fcnt_d;
      vid_q   <= vid_d;
    end
  end

  assign pixel_x     = x_q;
  assign pixel_y     = y_q;
  assign frame_tick  = tick_q;
  assign frame_count = fcnt_q;
  assign VGA_CLK     = phase_q;
  assign VGA_HS      = vid_q.hs;
  assign VGA_VS      = vid_q.vs;
  assign VGA_BLANK_N = vid_q.blank_n;
  assign VGA_R       = vid_q.rgb[23:16];
  assign VGA_G       = vid_q.rgb[15:8];
  assign VGA_B       = vid_q.rgb[7:0];

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing with a shrunken raster; expected outputs are derived from
// the number of pixel periods elapsed since reset release.
module tb_vga_timing;
  localparam int HA = 6, HF = 1, HS = 3, HB = 2;
  localparam int VA = 4, VF = 1, VS = 3, VB = 1;
  localparam int HT = HA + HF + HS + HB;   // 12
  localparam int VT = VA + VF + VS + VB;   // 9
  localparam int F  = HT * VT;             // pixels per frame
  localparam int TICK_PIX = VA * HT;       // pixel index of (0, VA)

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [23:0] rgb_in = 24'h0;
  logic [9:0]  pixel_x, pixel_y;
  logic        frame_tick;
  logic [7:0]  frame_count;
  logic        vga_clk, vga_hs, vga_vs, vga_blank_n;
  logic [7:0]  vga_r, vga_g, vga_b;

  int checks = 0;
  int errors = 0;
  int k = 0;   // CLOCK_50 edges since release
  int e = 0;   // enabled edges since release

  vga_timing #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .CLOCK_50(clk), .reset(rst_n), .rgb_in(rgb_in),
    .pixel_x(pixel_x), .pixel_y(pixel_y),
    .frame_tick(frame_tick), .frame_count(frame_count),
    .VGA_CLK(vga_clk), .VGA_HS(vga_hs), .VGA_VS(vga_vs), .VGA_BLANK_N(vga_blank_n),
    .VGA_R(vga_r), .VGA_G(vga_g), .VGA_B(vga_b)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b0;
    rgb_in = 24'($urandom);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (pixel_x !== 10'd0) begin errors++; $display("FAIL rst_x got %0d want 0", pixel_x); end
    checks++; if (pixel_y !== 10'd0) begin errors++; $display("FAIL rst_y got %0d want 0", pixel_y); end
    checks++; if (vga_clk !== 1'b0) begin errors++; $display("FAIL rst_vga_clk got %b want 0", vga_clk); end
    checks++; if (frame_tick !== 1'b0) begin errors++; $display("FAIL rst_tick got %b want 0", frame_tick); end
    checks++; if (frame_count !== 8'd0) begin errors++; $display("FAIL rst_fcnt got %0d want 0", frame_count); end
    checks++; if (vga_hs !== 1'b1) begin errors++; $display("FAIL rst_hs got %b want 1", vga_hs); end
    checks++; if (vga_vs !== 1'b1) begin errors++; $display("FAIL rst_vs got %b want 1", vga_vs); end
    checks++; if (vga_blank_n !== 1'b0) begin errors++; $display("FAIL rst_blank got %b want 0", vga_blank_n); end
    checks++; if ({vga_r, vga_g, vga_b} !== 24'h0) begin errors++; $display("FAIL rst_rgb got %h want 0", {vga_r, vga_g, vga_b}); end
    rst_n = 1'b1;
    k = 0; e = 0;
    #2;
    checks++; if ({pixel_x, vga_clk, vga_blank_n, vga_hs} !== {10'd0, 1'b0, 1'b0, 1'b1}) begin
      errors++; $display("FAIL release_glitch got x=%0d clk=%b blank=%b hs=%b", pixel_x, vga_clk, vga_blank_n, vga_hs);
    end
  endtask

  // Cycle-by-cycle comparison against the pixel-count model, random colours.
  task automatic test_frame();
    int ticks = 0;
    logic [23:0] rgb_cap = 24'h0;
    for (int c = 0; c < 4 * F; c++) begin
      int ex, ey, q, px, py, efc;
      bit vis, ehs, evs, etick;
      @(posedge clk);
      k++;
      if (k % 2 == 1) begin e++; rgb_cap = rgb_in; end
      @(negedge clk);
      ex = e % HT; ey = (e / HT) % VT;
      q = e - 1; px = q % HT; py = (q / HT) % VT;
      vis = (px < HA) && (py < VA);
      ehs = !((px >= HA + HF) && (px < HA + HF + HS));
      evs = !((py >= VA + VF) && (py < VA + VF + VS));
      etick = (k % 2 == 1) && (e % F == TICK_PIX);
      efc = (e >= TICK_PIX) ? (((e - TICK_PIX) / F + 1) % 256) : 0;
      if (frame_tick) ticks++;
      checks++; if (pixel_x !== 10'(ex)) begin errors++; $display("FAIL frm_x k=%0d got %0d want %0d", k, pixel_x, ex); end
      checks++; if (pixel_y !== 10'(ey)) begin errors++; $display("FAIL frm_y k=%0d got %0d want %0d", k, pixel_y, ey); end
      checks++; if (vga_clk !== 1'(k % 2)) begin errors++; $display("FAIL frm_vga_clk k=%0d got %b want %0d", k, vga_clk, k % 2); end
      checks++; if (vga_hs !== ehs) begin errors++; $display("FAIL frm_hs k=%0d got %b want %b", k, vga_hs, ehs); end
      checks++; if (vga_vs !== evs) begin errors++; $display("FAIL frm_vs k=%0d got %b want %b", k, vga_vs, evs); end
      checks++; if (vga_blank_n !== vis) begin errors++; $display("FAIL frm_blank k=%0d got %b want %b", k, vga_blank_n, vis); end
      checks++; if ({vga_r, vga_g, vga_b} !== (vis ? rgb_cap : 24'h0)) begin
        errors++; $display("FAIL frm_rgb k=%0d got %h want %h", k, {vga_r, vga_g, vga_b}, vis ? rgb_cap : 24'h0);
      end
      checks++; if (frame_tick !== etick) begin errors++; $display("FAIL frm_tick k=%0d got %b want %b", k, frame_tick, etick); end
      checks++; if (frame_count !== 8'(efc)) begin errors++; $display("FAIL frm_fcnt k=%0d got %0d want %0d", k, frame_count, efc); end
      if (c == 2 * F - 1) begin
        checks++; if ({pixel_x, pixel_y, frame_count} !== {10'd0, 10'd0, 8'd1} || ticks != 1) begin
          errors++; $display("FAIL one_frame got x=%0d y=%0d fc=%0d ticks=%0d want 0 0 1 1", pixel_x, pixel_y, frame_count, ticks);
        end
      end
      rgb_in = ($urandom_range(0, 1) == 0) ? 24'hFF8040 : 24'($urandom);
    end
  endtask

  // Per-frame pulse widths with a constant colour.
  task automatic test_sync_widths();
    int hs_lo = 0, vs_lo = 0, bl_hi = 0;
    rgb_in = 24'hFF8040;
    for (int c = 0; c < 2 * F; c++) begin
      @(posedge clk); k++;
      if (k % 2 == 1) e++;
      @(negedge clk);
      if (k % 2 == 1) begin
        if (!vga_hs) hs_lo++;
        if (!vga_vs) vs_lo++;
        if (vga_blank_n) bl_hi++;
        checks++; if ({vga_r, vga_g, vga_b} !== (vga_blank_n ? 24'hFF8040 : 24'h0)) begin
          errors++; $display("FAIL const_rgb k=%0d got %h blank=%b", k, {vga_r, vga_g, vga_b}, vga_blank_n);
        end
      end
    end
    checks++; if (hs_lo != HS * VT) begin errors++; $display("FAIL hs_width got %0d want %0d", hs_lo, HS * VT); end
    checks++; if (vs_lo != VS * HT) begin errors++; $display("FAIL vs_width got %0d want %0d", vs_lo, VS * HT); end
    checks++; if (bl_hi != HA * VA) begin errors++; $display("FAIL blank_width got %0d want %0d", bl_hi, HA * VA); end
  endtask

  task automatic test_mid_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    // 3 + 2*HT pixels in: (3, 2)
    repeat (2 * (2 * HT + 3) - 1) @(posedge clk);
    @(negedge clk);
    checks++; if ({pixel_x, pixel_y} !== {10'd3, 10'd2}) begin errors++; $display("FAIL mid_pos got %0d,%0d want 3,2", pixel_x, pixel_y); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if ({pixel_x, pixel_y, frame_count, frame_tick, vga_clk} !== 31'd0) begin
      errors++; $display("FAIL mid_rst_cnt got x=%0d y=%0d fc=%0d tick=%b clk=%b", pixel_x, pixel_y, frame_count, frame_tick, vga_clk);
    end
    checks++; if ({vga_hs, vga_vs, vga_blank_n, vga_r, vga_g, vga_b} !== {1'b1, 1'b1, 1'b0, 24'h0}) begin
      errors++; $display("FAIL mid_rst_vid got hs=%b vs=%b blank=%b rgb=%h", vga_hs, vga_vs, vga_blank_n, {vga_r, vga_g, vga_b});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if ({pixel_x, pixel_y, vga_clk} !== {10'd1, 10'd0, 1'b1}) begin
      errors++; $display("FAIL post_rst1 got x=%0d y=%0d clk=%b want 1 0 1", pixel_x, pixel_y, vga_clk);
    end
    @(posedge clk); #1;
    checks++; if ({pixel_x, vga_clk} !== {10'd1, 1'b0}) begin
      errors++; $display("FAIL post_rst2 got x=%0d clk=%b want 1 0", pixel_x, vga_clk);
    end
  endtask

  task automatic test_wrap();
    int ticks = 0;
    bit prev = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 2 * (TICK_PIX + 255 * F) + 20; c++) begin
      @(negedge clk);
      if (frame_tick) begin
        ticks++;
        checks++; if (prev) begin errors++; $display("FAIL tick_width tick=%0d high two cycles", ticks); end
        checks++; if (frame_count !== 8'(ticks)) begin errors++; $display("FAIL wrap_fcnt tick=%0d got %0d want %0d", ticks, frame_count, ticks % 256); end
      end
      prev = frame_tick;
    end
    checks++; if (ticks != 256) begin errors++; $display("FAIL wrap_ticks got %0d want 256", ticks); end
    checks++; if (frame_count !== 8'd0) begin errors++; $display("FAIL wrap_final got %0d want 0", frame_count); end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_sync_widths();
    test_mid_reset();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
